// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU and the shift-and-add multiply sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [1:0] ALUOP_SLLI = 2'b01;
  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_ADD   = 2'b01,
    SEQ_SHIFT = 2'b10,
    SEQ_DONE  = 2'b11
  } seq_state_e;

  // The sequencer owns the ALU only while it is stepping through ADD/SHIFT.
  function automatic logic seq_owns_alu(input seq_state_e st);
    return (st == SEQ_ADD) || (st == SEQ_SHIFT);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational datapath ALU: ADD, SUB and shift-left-immediate.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  // Operation select; the unused encoding yields zero.
  always_comb begin
    result = '0;
    case (op)
      ALUOP_ADD:  result = a + b;
      ALUOP_SUB:  result = a - b;
      ALUOP_SLLI: result = a << b[SH_W-1:0];
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle WIDTH x WIDTH (low half) multiplier that borrows the shared ALU
// for shift-and-add; every output is registered from the next-state values.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             alu_own_q, alu_own_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;

  // Next-state logic for the controller and the M/Q/P/count working registers.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          m_d     = op_a;
          q_d     = op_b;
          p_d     = '0;
          cnt_d   = '0;
          state_d = (op_b == '0) ? SEQ_DONE : SEQ_ADD;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_ADD: begin
        if (q_q[0]) begin
          p_d = alu_result;
        end else begin
          p_d = p_q;
        end
        state_d = SEQ_SHIFT;
      end
      SEQ_SHIFT: begin
        m_d   = alu_result;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        // Stop early once no multiplier bits remain.
        if ((q_d == '0) || (cnt_d == CNT_LAST)) begin
          state_d = SEQ_DONE;
        end else begin
          state_d = SEQ_ADD;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so ALU drive is ready at the edge
  // that enters ADD/SHIFT and alu_result is valid within that same cycle.
  always_comb begin
    ready_d   = (state_d == SEQ_IDLE);
    done_d    = (state_d == SEQ_DONE);
    alu_own_d = seq_owns_alu(state_d);
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_op_d  = ALUOP_ADD;
    if (state_d == SEQ_DONE) begin
      product_d = p_d;
    end else begin
      product_d = product_q;
    end
    case (state_d)
      SEQ_ADD: begin
        alu_a_d  = p_d;
        alu_b_d  = m_d;
        alu_op_d = ALUOP_ADD;
      end
      SEQ_SHIFT: begin
        alu_a_d  = m_d;
        alu_b_d  = {{(WIDTH-1){1'b0}}, 1'b1};
        alu_op_d = ALUOP_SLLI;
      end
      default: begin
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = ALUOP_ADD;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      alu_own_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= ALUOP_ADD;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      alu_own_q <= alu_own_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_own = alu_own_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: real ALU closes the loop; expected products/latencies
// are queued when an operation is issued and popped when done appears.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready, alu_own, done;
  logic [W-1:0] alu_a, alu_b, alu_result, product;
  logic [1:0]   alu_op;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_prod_q[$];
  int           exp_lat_q[$];

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .done(done), .product(product)
  );

  alu #(.WIDTH(W)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result));

  function automatic int model_lat(input logic [W-1:0] b);
    int h = -1;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return (h < 0) ? 1 : 2 * (h + 1) + 1;
  endfunction

  // Issues one operation and returns at the falling edge of cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    @(negedge clk);
    p = a * b;
    exp_prod_q.push_back(p);
    exp_lat_q.push_back(model_lat(b));
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
  endtask

  // Follows an operation until done (bounded); records ALU ownership and op order.
  task automatic collect(output int lat, output logic [W-1:0] prod,
                         output int own_cnt, output int bad_ops);
    lat = 0; prod = '0; own_cnt = 0; bad_ops = 0;
    for (int k = 1; k <= 40; k++) begin
      if (alu_own) begin
        own_cnt++;
        if (alu_op !== (((k % 2) == 1) ? ALUOP_ADD : ALUOP_SLLI)) bad_ops++;
      end
      if (done) begin
        lat = k; prod = product;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
    checks++; if ({alu_own, alu_a, alu_b, alu_op} !== {1'b0, 16'h0000, 16'h0000, ALUOP_ADD})
      begin errors++; $display("FAIL reset_alu got own=%b a=%h b=%h op=%b exp 0/0000/0000/10", alu_own, alu_a, alu_b, alu_op); end
    reset = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, own, bad, elat; logic [W-1:0] prod, eprod;
    issue(a, b);
    collect(lat, prod, own, bad);
    eprod = exp_prod_q.pop_front(); elat = exp_lat_q.pop_front();
    checks++; if (prod !== eprod) begin errors++; $display("FAIL %s_product got=%h exp=%h", name, prod, eprod); end
    checks++; if (lat != elat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, elat); end
    checks++; if (own != elat - 1 || bad != 0) begin errors++; $display("FAIL %s_alu_seq own=%0d exp=%0d badops=%0d", name, own, elat - 1, bad); end
  endtask

  task automatic test_basic();
    int lat, own, bad, elat; logic [W-1:0] prod, eprod;
    issue(16'd3, 16'd5);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got=%b exp=0", ready); end
    collect(lat, prod, own, bad);
    eprod = exp_prod_q.pop_front(); elat = exp_lat_q.pop_front();
    checks++; if (prod !== eprod || eprod !== 16'd15) begin errors++; $display("FAIL basic_product got=%0d exp=15", prod); end
    checks++; if (lat != 7 || elat != 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    checks++; if (own != 6 || bad != 0) begin errors++; $display("FAIL basic_alu_seq own=%0d exp=6 badops=%0d", own, bad); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_ready_after got ready=%b done=%b exp 1/0", ready, done); end
  endtask

  task automatic test_zero();
    run_and_check("zero", 16'd1234, 16'd0);
  endtask

  task automatic test_patterns();
    logic [W-1:0] ra, rb;
    run_and_check("p300", 16'd300, 16'd300);
    run_and_check("neg3x7", 16'hFFFD, 16'd7);
    run_and_check("max", 16'h0002, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run_and_check("rand", ra, rb);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] prev;
    run_and_check("b2b_first", 16'd77, 16'd11);
    prev = 16'd847;
    issue(16'd5, 16'h0101);
    checks++; if (product !== prev) begin errors++; $display("FAIL b2b_product_held got=%h exp=%h", product, prev); end
    exp_prod_q.delete(); exp_lat_q.delete();
    while (!ready) @(negedge clk);
    run_and_check("b2b_last", 16'h1234, 16'h0003);
  endtask

  task automatic test_start_ignored();
    int lat = 0, extra = 0;
    issue(16'd3, 16'd5);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (done) begin
        lat = k;
        checks++; if (product !== exp_prod_q[0]) begin errors++; $display("FAIL ign_product got=%0d exp=%0d", product, exp_prod_q[0]); end
      end
      @(negedge clk);
      if (k == 2) begin start = 1'b1; op_a = 16'd9; op_b = 16'd9; end
      else start = 1'b0;
    end
    start = 1'b0;
    checks++; if (lat != exp_lat_q[0]) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", lat, exp_lat_q[0]); end
    void'(exp_prod_q.pop_front()); void'(exp_lat_q.pop_front());
    for (int k = 0; k < 40; k++) begin
      if (done || alu_own) extra++;
      @(negedge clk);
    end
    checks++; if (extra != 0 || product !== 16'd15) begin errors++; $display("FAIL ign_no_extra got pulses=%0d product=%0d exp 0/15", extra, product); end
  endtask

  task automatic test_reset_mid();
    issue(16'd3, 16'd5);
    @(negedge clk);
    checks++; if (alu_own !== 1'b1 || alu_op !== ALUOP_SLLI) begin errors++; $display("FAIL mid_in_shift got own=%b op=%b exp 1/01", alu_own, alu_op); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_prod_q.delete(); exp_lat_q.delete();
    checks++; if ({ready, done, alu_own, product} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      begin errors++; $display("FAIL mid_reset got ready=%b done=%b own=%b product=%h exp 1/0/0/0000", ready, done, alu_own, product); end
    run_and_check("after_reset", 16'd2, 16'd2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_patterns();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
